serial_comp_ctrl: RTL

Bit-serial magnitude comparator controller. It captures two WIDTH-bit operands on a start request and walks them MSB-first through a single 1-bit G/E/L compare slice, one bit per clock. It terminates early at the first differing bit and reports a one-hot G/E/L result with a single-cycle done pulse. It sits in the behavioural comparator family as the sequenced, area-minimal alternative to a parallel N-bit comparator.

---
 rtl/serial_comp_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_comp_ctrl.sv
// Bit-serial magnitude comparator controller: walks two captured operands MSB-first
// through a 1-bit G/E/L slice, exiting at the first differing bit.
module serial_comp_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             G,
   output logic             E,
   output logic             L,
   output logic [CW-1:0]    nbits
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] ra_r;
   logic [WIDTH-1:0] rb_r;
   logic [IW-1:0]    idx_r;
   logic [2:0]       gel_s;

   // One-bit compare slice, result packed as {greater, equal, less}
   function automatic logic [2:0] slice_cmp(input logic x, input logic y);
      logic [2:0] r;
      case ({x, y})
         2'b10:   r = 3'b100;
         2'b01:   r = 3'b001;
         default: r = 3'b010;
      endcase
      return r;
   endfunction

   assign gel_s = slice_cmp(ra_r[idx_r], rb_r[idx_r]);

   // Sequencer: operand capture, serial bit walk and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ra_r    <= {WIDTH{1'b0}};
         rb_r    <= {WIDTH{1'b0}};
         idx_r   <= {IW{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         G       <= 1'b0;
         E       <= 1'b0;
         L       <= 1'b0;
         nbits   <= {CW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  ra_r    <= a;
                  rb_r    <= b;
                  idx_r   <= IW'(WIDTH - 1);
                  G       <= 1'b0;
                  E       <= 1'b0;
                  L       <= 1'b0;
                  nbits   <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state_r <= RUN;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               nbits <= nbits + CW'(1);
               if (gel_s[2] || gel_s[0]) begin
                  G       <= gel_s[2];
                  L       <= gel_s[0];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else if (idx_r == {IW{1'b0}}) begin
                  // all bits matched down to the LSB
                  E       <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  idx_r   <= idx_r - IW'(1);
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
